// File: rtl/pcpu_pkg.sv
// Shared encodings for the processor control path: opcodes, ALU modes,
// branch condition codes, decoder state enum and small opcode helpers.
package pcpu_pkg;

    localparam logic [6:0] OP_MOV = 7'h01;
    localparam logic [6:0] OP_LDD = 7'h02;
    localparam logic [6:0] OP_LDO = 7'h03;
    localparam logic [6:0] OP_LDI = 7'h04;
    localparam logic [6:0] OP_STD = 7'h05;
    localparam logic [6:0] OP_STO = 7'h06;
    localparam logic [6:0] OP_ADD = 7'h07;
    localparam logic [6:0] OP_ADI = 7'h08;
    localparam logic [6:0] OP_ADC = 7'h09;
    localparam logic [6:0] OP_SUB = 7'h0A;
    localparam logic [6:0] OP_SUC = 7'h0B;
    localparam logic [6:0] OP_CMP = 7'h0C;
    localparam logic [6:0] OP_CMI = 7'h0D;
    localparam logic [6:0] OP_JMP = 7'h0E;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_PASS_L = 4'b1001;
    localparam logic [3:0] ALU_PASS_R = 4'b1010;

    localparam logic [3:0] COND_C   = 4'd1;
    localparam logic [3:0] COND_EQ  = 4'd2;
    localparam logic [3:0] COND_LT  = 4'd3;
    localparam logic [3:0] COND_GT  = 4'd4;
    localparam logic [3:0] COND_LE  = 4'd5;
    localparam logic [3:0] COND_GE  = 4'd6;
    localparam logic [3:0] COND_NE  = 4'd7;
    localparam logic [3:0] COND_OV  = 4'd8;
    localparam logic [3:0] COND_OV2 = 4'd9;

    typedef enum logic [2:0] {
        ST_EXEC     = 3'd0,
        ST_MEM_REQ  = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_MEM_WB   = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    // Memory-access opcodes leave EXEC and run the handshake sequence.
    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LDD) || (op == OP_LDO) || (op == OP_STD) || (op == OP_STO);
    endfunction

    // Loads write back into a GP register; stores finish straight from MEM_WAIT.
    function automatic logic is_load_op(input logic [6:0] op);
        return (op == OP_LDD) || (op == OP_LDO);
    endfunction

endpackage

// File: rtl/ctl_decoder_jmp_cond.sv
// Branch condition evaluator: turns the 4-bit cond field and the ALU flags
// into the jump-enable used by the jmp opcode.
module jmp_cond
    import pcpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       jmp_en
);

    // flags[4] is reserved and intentionally ignored
    logic unused_flag_s;
    assign unused_flag_s = flags[4];

    // Select the flag expression for the requested condition; unknown codes jump
    always_comb begin
        jmp_en = 1'b1;
        case (cond)
            COND_C:   jmp_en = flags[1];
            COND_EQ:  jmp_en = flags[0];
            COND_LT:  jmp_en = flags[2];
            COND_GT:  jmp_en = ~(flags[2] | flags[0]);
            COND_LE:  jmp_en = flags[2] | flags[0];
            COND_GE:  jmp_en = ~flags[2];
            COND_NE:  jmp_en = ~flags[0];
            COND_OV:  jmp_en = flags[3];
            COND_OV2: jmp_en = flags[3];
            default:  jmp_en = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctl_decoder.sv
// Control decoder: single-cycle opcodes decode combinationally in EXEC;
// memory opcodes latch the instruction and walk MEM_REQ/MEM_WAIT/MEM_WB
// with a timeout that traps into FAULT until software clears it.
module ctl_decoder
    import pcpu_pkg::*;
#(
    parameter int REG_CNT     = 8,
    parameter int INSTR_W     = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INSTR_W-1:0]            instr,
    input  logic                          instr_valid,
    input  logic                          mem_busy,
    input  logic                          mem_ready,
    input  logic [4:0]                    flags,
    input  logic                          fault_clr,
    output logic                          pc_inc,
    output logic                          pc_ie,
    output logic                          reg_in_mux_ctl,
    output logic                          alu_r_mux_ctl,
    output logic                          alu_cin,
    output logic                          ram_write,
    output logic                          ram_read,
    output logic                          alu_flags_ie,
    output logic [3:0]                    alu_mode,
    output logic [$clog2(REG_CNT)-1:0]    reg_l_ctl,
    output logic [$clog2(REG_CNT)-1:0]    reg_r_ctl,
    output logic [REG_CNT-1:0]            gp_reg_ie,
    output logic                          mem_fault,
    output logic                          busy
);

    localparam int RW = $clog2(REG_CNT);
    localparam logic [15:0]        WAIT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [REG_CNT-1:0] IE_ONE    = {{(REG_CNT-1){1'b0}}, 1'b1};
    localparam logic [REG_CNT-1:0] IE_NONE   = {REG_CNT{1'b0}};

    state_e               state_r;
    state_e               next_state_s;
    logic [INSTR_W-1:0]   instr_r;
    logic [15:0]          wait_cnt_r;
    logic                 mem_fault_r;
    logic                 latch_s;
    logic                 fault_set_s;
    logic                 timeout_s;
    logic                 jmp_en_s;

    // Live instruction fields (EXEC) and latched fields (memory states)
    logic [6:0]    op_s, op_m_s;
    logic [RW-1:0] tg_s, fo_s, so_s, tg_m_s, fo_m_s, so_m_s;
    logic [3:0]    cond_s;

    assign op_s   = instr[6:0];
    assign tg_s   = instr[7+RW-1:7];
    assign fo_s   = instr[7+2*RW-1:7+RW];
    assign so_s   = instr[7+3*RW-1:7+2*RW];
    assign cond_s = instr[10:7];
    assign op_m_s = instr_r[6:0];
    assign tg_m_s = instr_r[7+RW-1:7];
    assign fo_m_s = instr_r[7+2*RW-1:7+RW];
    assign so_m_s = instr_r[7+3*RW-1:7+2*RW];

    assign timeout_s = (wait_cnt_r == WAIT_LAST);

    jmp_cond u_jmp_cond (
        .cond   (cond_s),
        .flags  (flags),
        .jmp_en (jmp_en_s)
    );

    // Address-setup controls held steady for the whole memory sequence
    logic          mem_load_s;
    logic [3:0]    mem_mode_s;
    logic [RW-1:0] mem_l_s, mem_r_s;

    // Derive the memory address-setup from the latched opcode
    always_comb begin
        mem_load_s = is_load_op(op_m_s);
        mem_mode_s = ALU_PASS_R;
        mem_l_s    = {RW{1'b0}};
        mem_r_s    = {RW{1'b0}};
        case (op_m_s)
            OP_LDO: begin
                mem_mode_s = ALU_ADD;
                mem_l_s    = fo_m_s;
            end
            OP_STD: begin
                mem_r_s    = fo_m_s;
            end
            OP_STO: begin
                mem_mode_s = ALU_ADD;
                mem_l_s    = so_m_s;
                mem_r_s    = fo_m_s;
            end
            default: begin
                mem_mode_s = ALU_PASS_R;
            end
        endcase
    end

    // Decoded (pre-reset-gating) datapath controls
    logic                pc_inc_s, pc_ie_s, reg_in_mux_s, alu_r_mux_s;
    logic                alu_cin_s, ram_write_s, ram_read_s, alu_flags_ie_s;
    logic [3:0]          alu_mode_s;
    logic [RW-1:0]       reg_l_s, reg_r_s;
    logic [REG_CNT-1:0]  gp_reg_ie_s;

    // Next-state and output decode from state plus instruction
    always_comb begin
        next_state_s   = state_r;
        latch_s        = 1'b0;
        fault_set_s    = 1'b0;
        pc_inc_s       = 1'b0;
        pc_ie_s        = 1'b0;
        reg_in_mux_s   = 1'b0;
        alu_r_mux_s    = 1'b0;
        alu_cin_s      = 1'b0;
        ram_write_s    = 1'b0;
        ram_read_s     = 1'b0;
        alu_flags_ie_s = 1'b0;
        alu_mode_s     = 4'b0000;
        reg_l_s        = {RW{1'b0}};
        reg_r_s        = {RW{1'b0}};
        gp_reg_ie_s    = IE_NONE;
        case (state_r)
            ST_EXEC: begin
                if (instr_valid) begin
                    case (op_s)
                        OP_MOV: begin
                            alu_mode_s  = ALU_PASS_L;
                            reg_l_s     = fo_s;
                            gp_reg_ie_s = IE_ONE << tg_s;
                            pc_inc_s    = 1'b1;
                        end
                        OP_LDI: begin
                            alu_mode_s  = ALU_PASS_R;
                            alu_r_mux_s = 1'b1;
                            gp_reg_ie_s = IE_ONE << tg_s;
                            pc_inc_s    = 1'b1;
                        end
                        OP_ADD, OP_ADC, OP_SUB, OP_SUC, OP_CMP: begin
                            alu_mode_s     = ((op_s == OP_ADD) || (op_s == OP_ADC)) ? ALU_ADD : ALU_SUB;
                            alu_cin_s      = ((op_s == OP_ADC) || (op_s == OP_SUC)) ? flags[1] : 1'b0;
                            reg_l_s        = fo_s;
                            reg_r_s        = so_s;
                            gp_reg_ie_s    = (op_s == OP_CMP) ? IE_NONE : (IE_ONE << tg_s);
                            alu_flags_ie_s = 1'b1;
                            pc_inc_s       = 1'b1;
                        end
                        OP_ADI, OP_CMI: begin
                            alu_mode_s     = (op_s == OP_ADI) ? ALU_ADD : ALU_SUB;
                            reg_l_s        = fo_s;
                            alu_r_mux_s    = 1'b1;
                            gp_reg_ie_s    = (op_s == OP_CMI) ? IE_NONE : (IE_ONE << tg_s);
                            alu_flags_ie_s = 1'b1;
                            pc_inc_s       = 1'b1;
                        end
                        OP_JMP: begin
                            alu_mode_s  = ALU_PASS_R;
                            alu_r_mux_s = 1'b1;
                            pc_ie_s     = jmp_en_s;
                            pc_inc_s    = ~jmp_en_s;
                        end
                        OP_LDD, OP_LDO, OP_STD, OP_STO: begin
                            latch_s      = 1'b1;
                            next_state_s = ST_MEM_REQ;
                        end
                        default: begin
                            pc_inc_s = 1'b1;
                        end
                    endcase
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_MEM_REQ: begin
                alu_mode_s  = mem_mode_s;
                reg_l_s     = mem_l_s;
                reg_r_s     = mem_r_s;
                alu_r_mux_s = 1'b1;
                if (mem_load_s) begin
                    ram_read_s   = 1'b1;
                    reg_in_mux_s = 1'b1;
                end else begin
                    ram_write_s  = 1'b1;
                end
                next_state_s = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                alu_mode_s  = mem_mode_s;
                reg_l_s     = mem_l_s;
                reg_r_s     = mem_r_s;
                alu_r_mux_s = 1'b1;
                if (mem_load_s) begin
                    if (mem_ready) begin
                        next_state_s = ST_MEM_WB;
                    end else if (timeout_s) begin
                        next_state_s = ST_FAULT;
                        fault_set_s  = 1'b1;
                    end else begin
                        next_state_s = ST_MEM_WAIT;
                    end
                end else begin
                    if (!mem_busy) begin
                        next_state_s = ST_EXEC;
                        pc_inc_s     = 1'b1;
                    end else if (timeout_s) begin
                        next_state_s = ST_FAULT;
                        fault_set_s  = 1'b1;
                    end else begin
                        next_state_s = ST_MEM_WAIT;
                    end
                end
            end
            ST_MEM_WB: begin
                alu_mode_s   = mem_mode_s;
                reg_l_s      = mem_l_s;
                reg_r_s      = mem_r_s;
                alu_r_mux_s  = 1'b1;
                reg_in_mux_s = 1'b1;
                gp_reg_ie_s  = IE_ONE << tg_m_s;
                pc_inc_s     = 1'b1;
                next_state_s = ST_EXEC;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_EXEC;
            end
        endcase
    end

    // Force every output low while reset is asserted, even mid-sequence
    always_comb begin
        if (rst) begin
            pc_inc         = 1'b0;
            pc_ie          = 1'b0;
            reg_in_mux_ctl = 1'b0;
            alu_r_mux_ctl  = 1'b0;
            alu_cin        = 1'b0;
            ram_write      = 1'b0;
            ram_read       = 1'b0;
            alu_flags_ie   = 1'b0;
            alu_mode       = 4'b0000;
            reg_l_ctl      = {RW{1'b0}};
            reg_r_ctl      = {RW{1'b0}};
            gp_reg_ie      = IE_NONE;
            mem_fault      = 1'b0;
            busy           = 1'b0;
        end else begin
            pc_inc         = pc_inc_s;
            pc_ie          = pc_ie_s;
            reg_in_mux_ctl = reg_in_mux_s;
            alu_r_mux_ctl  = alu_r_mux_s;
            alu_cin        = alu_cin_s;
            ram_write      = ram_write_s;
            ram_read       = ram_read_s;
            alu_flags_ie   = alu_flags_ie_s;
            alu_mode       = alu_mode_s;
            reg_l_ctl      = reg_l_s;
            reg_r_ctl      = reg_r_s;
            gp_reg_ie      = gp_reg_ie_s;
            mem_fault      = mem_fault_r;
            busy           = (state_r != ST_EXEC);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EXEC;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the memory instruction so later instr changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r <= {INSTR_W{1'b0}};
        end else if (latch_s) begin
            instr_r <= instr;
        end
    end

    // Count MEM_WAIT cycles, restarting for each new memory access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 16'd0;
        end else if (latch_s) begin
            wait_cnt_r <= 16'd0;
        end else if (state_r == ST_MEM_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end
    end

    // Sticky timeout flag: set on timeout, cleared by fault_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_fault_r <= 1'b0;
        end else if (fault_set_s) begin
            mem_fault_r <= 1'b1;
        end else if (fault_clr) begin
            mem_fault_r <= 1'b0;
        end
    end

endmodule

// File: doc/ctl_decoder.md
CTL_DECODER -- requirements
Module: ctl_decoder

Interface
REQ-001 Parameter REG_CNT, default 8, number of GP registers (power of two, 2..16); RW = clog2(REG_CNT).
REQ-002 Parameter INSTR_W, default 16, instruction width; SHALL satisfy INSTR_W >= 7+3*RW.
REQ-003 Parameter MEM_TIMEOUT, default 255, max MEM_WAIT cycles before fault (1..65535).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 instr  in  INSTR_W  instruction; opcode [6:0], tg [7+RW-1:7], fo [7+2RW-1:7+RW], so [7+3RW-1:7+2RW], cond [10:7].
REQ-007 instr_valid  in  1  instr is meaningful this cycle.
REQ-008 mem_busy, mem_ready  in  1 each  memory handshake.
REQ-009 flags  in  5  [0] eq, [1] carry, [2] lt, [3] ovf, [4] reserved.
REQ-010 fault_clr  in  1  clears mem_fault.
REQ-011 pc_inc, pc_ie, reg_in_mux_ctl, alu_r_mux_ctl, alu_cin, ram_write, ram_read, alu_flags_ie  out  1 each  datapath controls.
REQ-012 alu_mode  out  4; reg_l_ctl, reg_r_ctl  out  RW; gp_reg_ie  out  REG_CNT one-hot-or-zero.
REQ-013 mem_fault  out  1  sticky memory-timeout flag; busy  out  1  high in any state but EXEC.

Function
REQ-014 States SHALL be EXEC, MEM_REQ, MEM_WAIT, MEM_WB, FAULT; outputs are decoded from state plus instruction.
REQ-015 In EXEC with instr_valid=0, every output SHALL be 0 (bubble, pc_inc=0).
REQ-016 In EXEC, single-cycle opcodes SHALL decode in zero cycles: 01 mov (mode 1001, l=fo, ie[tg]); 04 ldi (1010, rmux, ie[tg]); 07 add/0A sub (0000/0001, l=fo, r=so, ie[tg], flags_ie); 08 adi (0000, l=fo, rmux, ie[tg], flags_ie); 09 adc/0B suc as add/sub with alu_cin=flags[1]; 0C cmp, 0D cmi as sub/subtract-immediate without ie; 0E jmp (1010, rmux, pc_ie=jmp_en, pc_inc=~jmp_en); unlisted = nop, pc_inc=1 only.
REQ-017 jmp_en by cond: 1 flags[1]; 2 flags[0]; 3 flags[2]; 4 ~(flags[2]|flags[0]); 5 flags[2]|flags[0]; 6 ~flags[2]; 7 ~flags[0]; 8,9 flags[3]; others 1.
REQ-018 Opcodes 02 ldd, 03 ldo, 05 std, 06 sto SHALL latch instr into an internal register and go to MEM_REQ next cycle; in EXEC that cycle pc_inc=0 and no other output high.
REQ-019 Memory address setup SHALL be held constant in MEM_REQ, MEM_WAIT, MEM_WB: ldd/std mode 1010, rmux; ldo l=fo, mode 0000, rmux; sto l=so, mode 0000, rmux; stores also drive r=fo.
REQ-020 MEM_REQ SHALL last one cycle with ram_read (loads, plus reg_in_mux_ctl) or ram_write (stores) high, pc_inc=0, then go to MEM_WAIT.
REQ-021 MEM_WAIT: pc_inc=0; loads exit to MEM_WB on mem_ready (mem_ready wins over simultaneous mem_busy); stores exit to EXEC with pc_inc=1 that cycle when mem_busy=0.
REQ-022 MEM_WB SHALL last one cycle: reg_in_mux_ctl=1, gp_reg_ie[tg]=1, pc_inc=1, then EXEC.
REQ-023 A wait counter SHALL clear on MEM_REQ entry and increment each MEM_WAIT cycle; reaching MEM_TIMEOUT without completion SHALL enter FAULT and set mem_fault.
REQ-024 FAULT: all datapath outputs 0; exit to EXEC when fault_clr=1, clearing mem_fault; fault_clr in other states SHALL clear mem_fault only.
REQ-025 instr and instr_valid changes outside EXEC SHALL be ignored.

Reset
REQ-026 rst SHALL immediately force state EXEC, clear latched instr, wait counter and mem_fault; all outputs 0 while rst is high, including mid-memory operation.

Structure
REQ-027 Opcode values, ALU mode constants, cond codes and state enum SHALL reside in shared package pcpu_pkg.
REQ-028 The jmp_en condition evaluator SHALL be sub-module jmp_cond (cond, flags -> jmp_en).

Verification
REQ-029 add r3,r1,r2 with instr_valid=1 -> same cycle gp_reg_ie=8'h08, reg_l=1, reg_r=2, alu_mode=0000, alu_flags_ie=1, pc_inc=1.
REQ-030 ldd r5, mem_busy 3 cycles then mem_ready -> ram_read one cycle, pc_inc=0 for 5 cycles, then gp_reg_ie=8'h20 with pc_inc=1; alu_mode 1010 throughout.
REQ-031 jle (cond 5) flags=5'b00100 -> pc_ie=1, pc_inc=0; flags=0 -> pc_ie=0, pc_inc=1.
REQ-032 MEM_TIMEOUT=4, sto with mem_busy stuck -> FAULT after 4 wait cycles, mem_fault=1 until fault_clr pulse.
REQ-033 rst asserted during MEM_WAIT -> all outputs 0 asynchronously; after release, EXEC, mem_fault=0.
REQ-034 REG_CNT=16, INSTR_W=19, mov r12,r9 -> gp_reg_ie=16'h1000, reg_l_ctl=9.
